// File: rtl/ram_fifo_mover_if.sv
// RAM read port plus FIFO write port seen by the mover; master = mover side, slave = RAM/FIFO side.
// Pure wiring bundle: no latency, and backpressure is the slave's fifo_full.
interface ram_fifo_mover_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_wrreq;
    logic              fifo_full;

    modport master (
        output ram_addr,
        output ram_rden,
        output fifo_data_out,
        output fifo_wrreq,
        input  ram_data_in,
        input  fifo_full
    );

    modport slave (
        input  ram_addr,
        input  ram_rden,
        input  fifo_data_out,
        input  fifo_wrreq,
        output ram_data_in,
        output fifo_full
    );
endinterface

// File: rtl/ram_fifo_mover.sv
// Copies a BURST_LEN-word burst from RAM into a FIFO on a timer, manual or continuous trigger.
// RAM_LATENCY+2 cycles per word; holds in WRITE while fifo_full, dropped triggers raise sticky overrun.
module ram_fifo_mover #(
    parameter int CLK_FREQ      = 50000000,
    parameter int UPDATE_PERIOD = 1500,
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 5,
    parameter int BURST_LEN     = 32,
    parameter int BASE_ADDR     = 0,
    parameter int RAM_LATENCY   = 1,
    parameter int MODE          = 0
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    input  logic               start,
    ram_fifo_mover_if.master   bus,
    output logic               busy,
    output logic               burst_done,
    output logic               overrun
);

    localparam logic [63:0] PERIOD_TICKS = (64'(CLK_FREQ) / 64'd1000) * 64'(UPDATE_PERIOD);
    localparam int          TMR_W        = $clog2(PERIOD_TICKS);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(PERIOD_TICKS - 64'd1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(BURST_LEN - 1);
    localparam logic [2:0]        LAT_LOAD  = 3'(RAM_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q,   tmr_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [ADDR_W-1:0]   idx_q,   idx_d;
    logic [2:0]          lat_q,   lat_d;
    logic [DATA_W-1:0]   dat_q,   dat_d;
    logic                rden_q,  rden_d;
    logic                wrreq_q, wrreq_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                ovr_q,   ovr_d;

    logic                tick;
    logic                trig_req;
    logic                auto_trig;

    // Free-running period timer; parked at zero while disabled or in continuous mode.
    always_comb begin
        tick  = 1'b0;
        tmr_d = '0;
        if (MODE == 0 && enable) begin
            if (tmr_q == TMR_LAST) begin
                tick = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    assign trig_req  = enable & (tick | start);
    assign auto_trig = (MODE == 1) && enable;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        dat_d   = dat_q;
        rden_d  = 1'b0;
        wrreq_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // busy_q also covers the DONE cycle, so a trigger there is dropped too.
        ovr_d   = ovr_q | (busy_q & trig_req);

        case (state_q)
            S_IDLE: begin
                if (trig_req || auto_trig) begin
                    addr_d  = BASE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    rden_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_q - 3'd1;
                // Last wait cycle: the RAM word for this address is on ram_data_in now.
                if (lat_q == 3'd1) begin
                    dat_d   = bus.ram_data_in;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!bus.fifo_full) begin
                    wrreq_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        rden_d  = 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            addr_q  <= BASE;
            idx_q   <= '0;
            lat_q   <= '0;
            dat_q   <= '0;
            rden_q  <= 1'b0;
            wrreq_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            dat_q   <= dat_d;
            rden_q  <= rden_d;
            wrreq_q <= wrreq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.ram_addr      = addr_q;
    assign bus.ram_rden      = rden_q;
    assign bus.fifo_data_out = dat_q;
    assign bus.fifo_wrreq    = wrreq_q;
    assign busy              = busy_q;
    assign burst_done        = done_q;
    assign overrun           = ovr_q;

endmodule

// File: tb/tb_ram_fifo_mover.sv
// Three mover instances (periodic, wrapping/slow RAM, continuous) driven with random start/full/enable
// and compared cycle by cycle against a schedule computed from the burst timing rules.
module tb_ram_fifo_mover;

    localparam int MAXC = 512;
    localparam int LAT  [3] = '{1, 3, 2};
    localparam int BLEN [3] = '{4, 4, 3};
    localparam int BASE [3] = '{2, 6, 14};
    localparam int AW   [3] = '{5, 3, 4};
    localparam int MD   [3] = '{0, 0, 1};
    localparam int PT   [3] = '{20, 30, 20};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_i [3];
    logic        en_i  [3];
    logic        st_i  [3];
    logic        fl_i  [3];
    logic [15:0] rd_i  [3];
    logic [7:0]  o_addr[3];
    logic        o_rden[3];
    logic        o_wr  [3];
    logic        o_busy[3];
    logic        o_done[3];
    logic        o_ovr [3];
    logic [15:0] o_dat [3];

    logic [15:0] mem [3][32];
    logic        p_v [3][4];
    logic [4:0]  p_a [3][4];

    ram_fifo_mover_if #(.DATA_W(16), .ADDR_W(AW[0])) bus0 ();
    ram_fifo_mover_if #(.DATA_W(16), .ADDR_W(AW[1])) bus1 ();
    ram_fifo_mover_if #(.DATA_W(16), .ADDR_W(AW[2])) bus2 ();

    ram_fifo_mover #(.CLK_FREQ(1000), .UPDATE_PERIOD(PT[0]), .DATA_W(16), .ADDR_W(AW[0]),
        .BURST_LEN(BLEN[0]), .BASE_ADDR(BASE[0]), .RAM_LATENCY(LAT[0]), .MODE(MD[0])) dut0 (
        .clock(clock), .rst(rst_i[0]), .enable(en_i[0]), .start(st_i[0]), .bus(bus0.master),
        .busy(o_busy[0]), .burst_done(o_done[0]), .overrun(o_ovr[0]));
    ram_fifo_mover #(.CLK_FREQ(1000), .UPDATE_PERIOD(PT[1]), .DATA_W(16), .ADDR_W(AW[1]),
        .BURST_LEN(BLEN[1]), .BASE_ADDR(BASE[1]), .RAM_LATENCY(LAT[1]), .MODE(MD[1])) dut1 (
        .clock(clock), .rst(rst_i[1]), .enable(en_i[1]), .start(st_i[1]), .bus(bus1.master),
        .busy(o_busy[1]), .burst_done(o_done[1]), .overrun(o_ovr[1]));
    ram_fifo_mover #(.CLK_FREQ(1000), .UPDATE_PERIOD(PT[2]), .DATA_W(16), .ADDR_W(AW[2]),
        .BURST_LEN(BLEN[2]), .BASE_ADDR(BASE[2]), .RAM_LATENCY(LAT[2]), .MODE(MD[2])) dut2 (
        .clock(clock), .rst(rst_i[2]), .enable(en_i[2]), .start(st_i[2]), .bus(bus2.master),
        .busy(o_busy[2]), .burst_done(o_done[2]), .overrun(o_ovr[2]));

    assign bus0.fifo_full = fl_i[0];
    assign bus1.fifo_full = fl_i[1];
    assign bus2.fifo_full = fl_i[2];
    assign bus0.ram_data_in = rd_i[0];
    assign bus1.ram_data_in = rd_i[1];
    assign bus2.ram_data_in = rd_i[2];
    assign o_addr[0] = {3'd0, bus0.ram_addr};
    assign o_addr[1] = {5'd0, bus1.ram_addr};
    assign o_addr[2] = {4'd0, bus2.ram_addr};
    assign o_rden[0] = bus0.ram_rden;
    assign o_rden[1] = bus1.ram_rden;
    assign o_rden[2] = bus2.ram_rden;
    assign o_wr[0]   = bus0.fifo_wrreq;
    assign o_wr[1]   = bus1.fifo_wrreq;
    assign o_wr[2]   = bus2.fifo_wrreq;
    assign o_dat[0]  = bus0.fifo_data_out;
    assign o_dat[1]  = bus1.fifo_data_out;
    assign o_dat[2]  = bus2.fifo_data_out;

    // Synchronous-read RAM: data valid LAT cycles after the strobe, garbage otherwise.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            p_v[i][0] <= o_rden[i];
            p_a[i][0] <= o_addr[i][4:0];
            for (int j = 1; j < 4; j++) begin
                p_v[i][j] <= p_v[i][j-1];
                p_a[i][j] <= p_a[i][j-1];
            end
        end
    end
    assign rd_i[0] = p_v[0][LAT[0]-1] ? mem[0][p_a[0][LAT[0]-1]] : 16'hDEAD;
    assign rd_i[1] = p_v[1][LAT[1]-1] ? mem[1][p_a[1][LAT[1]-1]] : 16'hDEAD;
    assign rd_i[2] = p_v[2][LAT[2]-1] ? mem[2][p_a[2][LAT[2]-1]] : 16'hDEAD;

    int n_chk = 0;
    int n_err = 0;
    int cur   = 0;
    int ncyc  = 0;

    bit          lg_en[MAXC], lg_st[MAXC], lg_fl[MAXC], lg_rden[MAXC], lg_wr[MAXC];
    bit          lg_busy[MAXC], lg_done[MAXC], lg_ovr[MAXC];
    logic [7:0]  lg_addr[MAXC];
    logic [15:0] lg_dat[MAXC];
    bit          e_rden[MAXC], e_wr[MAXC], e_busy[MAXC], e_done[MAXC], e_ovr[MAXC];
    logic [7:0]  e_addr[MAXC];
    logic [15:0] e_dat[MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst(input int i, input string tag);
        chk({tag, "_ctl"}, {27'd0, o_busy[i], o_done[i], o_ovr[i], o_rden[i], o_wr[i]}, 32'd0);
        chk({tag, "_addr"}, o_addr[i], BASE[i]);
        chk({tag, "_dat"}, o_dat[i], 32'd0);
    endtask

    task automatic begin_scn(input int i);
        cur = i;
        @(posedge clock); #1;
        rst_i[i] = 1'b1; en_i[i] = 1'b0; st_i[i] = 1'b0; fl_i[i] = 1'b0;
        @(negedge clock);
        chk_rst(i, $sformatf("reset%0d", i));
        for (int c = 0; c < MAXC; c++) begin
            lg_en[c] = 0; lg_st[c] = 0; lg_fl[c] = 0; lg_rden[c] = 0; lg_wr[c] = 0;
            lg_busy[c] = 0; lg_done[c] = 0; lg_ovr[c] = 0; lg_addr[c] = '0; lg_dat[c] = '0;
        end
        ncyc = 0;
    endtask

    // One clock cycle: drive inputs just after the edge, record everything mid-cycle.
    task automatic step(input bit en, input bit st, input bit fl);
        @(posedge clock); #1;
        rst_i[cur] = 1'b0;
        en_i[cur] = en; st_i[cur] = st; fl_i[cur] = fl;
        @(negedge clock);
        if (ncyc < MAXC) begin
            lg_en[ncyc] = en; lg_st[ncyc] = st; lg_fl[ncyc] = fl;
            lg_rden[ncyc] = o_rden[cur]; lg_addr[ncyc] = o_addr[cur];
            lg_wr[ncyc] = o_wr[cur]; lg_dat[ncyc] = o_dat[cur];
            lg_busy[ncyc] = o_busy[cur]; lg_done[ncyc] = o_done[cur]; lg_ovr[ncyc] = o_ovr[cur];
            ncyc++;
        end
    endtask

    // Expected events of one burst triggered in cycle t0; returns the DONE cycle.
    task automatic plan_burst(input int i, input int t0, output int t_done);
        int t, w, a;
        t = t0 + 1;
        for (int k = 0; k < BLEN[i]; k++) begin
            a = (BASE[i] + k) % (1 << AW[i]);
            if (t < MAXC) begin e_rden[t] = 1; e_addr[t] = 8'(a); end
            w = t + LAT[i] + 1;
            while (w < MAXC && lg_fl[w]) w++;
            t = w + 1;
            if (t < MAXC) begin e_wr[t] = 1; e_dat[t] = mem[i][a]; end
        end
        for (int c = t0 + 1; c <= t && c < MAXC; c++) e_busy[c] = 1;
        if (t < MAXC) e_done[t] = 1;
        t_done = t;
    endtask

    task automatic model_check(input int i, input string nm);
        int cnt, bend, dn;
        bit tick, att, ovr;
        for (int c = 0; c < MAXC; c++) begin
            e_rden[c] = 0; e_wr[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_ovr[c] = 0;
            e_addr[c] = '0; e_dat[c] = '0;
        end
        cnt = 0; bend = -1; ovr = 0;
        for (int c = 0; c < ncyc; c++) begin
            tick = (MD[i] == 0) && lg_en[c] && (cnt == PT[i] - 1);
            att  = lg_en[c] && (tick || lg_st[c]);
            e_ovr[c] = ovr;
            if (c <= bend) begin
                if (att) ovr = 1;
            end else if (att || (MD[i] == 1 && lg_en[c])) begin
                plan_burst(i, c, dn);
                bend = dn;
            end
            if (!lg_en[c] || cnt == PT[i] - 1) cnt = 0;
            else cnt++;
        end
        for (int c = 0; c < ncyc; c++) begin
            chk($sformatf("%s_ctl@%0d", nm, c),
                {27'd0, lg_busy[c], lg_done[c], lg_ovr[c], lg_rden[c], lg_wr[c]},
                {27'd0, e_busy[c], e_done[c], e_ovr[c], e_rden[c], e_wr[c]});
            if (e_rden[c]) chk($sformatf("%s_addr@%0d", nm, c), lg_addr[c], e_addr[c]);
            if (e_wr[c])   chk($sformatf("%s_dat@%0d", nm, c), lg_dat[c], e_dat[c]);
        end
    endtask

    function automatic int count_wr(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (lg_wr[c]) n++;
        return n;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_i[i] = 1'b0; en_i[i] = 1'b0; st_i[i] = 1'b0; fl_i[i] = 1'b0;
        end
        for (int a = 0; a < 32; a++) begin
            mem[0][a] = 16'(a * 3);
            mem[1][a] = 16'($urandom);
            mem[2][a] = 16'($urandom);
        end
        #1;
        for (int i = 0; i < 3; i++) rst_i[i] = 1'b1;

        // Periodic bursts, then a 10-cycle full during word 2 of the fifth burst.
        begin_scn(0);
        for (int c = 0; c < 120; c++) step(1'b1, 1'b0, (c >= 87 && c <= 96));
        chk("pd_first_rden", {31'd0, lg_rden[20]}, 32'd1);
        chk("pd_done13", {31'd0, lg_done[32]}, 32'd1);
        chk("pd_words", {lg_dat[23], lg_dat[26]}, {16'd6, 16'd9});
        chk("pd_repeat", {30'd0, lg_rden[40], lg_rden[60]}, 32'd3);
        chk("bp_nowr", count_wr(87, 96), 32'd0);
        chk("bp_word2", {15'd0, lg_wr[98], lg_dat[98]}, {15'd0, 1'b1, 16'd12});
        chk("bp_count", count_wr(80, 101), 32'd4);
        model_check(0, "periodic");

        // Start coincident with tick, start mid-burst, then random traffic.
        begin_scn(0);
        for (int c = 0; c < 200; c++) begin
            if (c < 40) step(1'b1, (c == 19 || c == 25), 1'b0);
            else step(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 3) == 0));
        end
        chk("ovr_pre", {31'd0, lg_ovr[25]}, 32'd0);
        chk("ovr_set", {31'd0, lg_ovr[26]}, 32'd1);
        chk("ovr_sticky", {31'd0, lg_ovr[ncyc-1]}, 32'd1);
        chk("one_burst", count_wr(20, 39), 32'd4);
        model_check(0, "overrun");

        // Address wrap with a three-cycle RAM.
        begin_scn(1);
        for (int c = 0; c < 200; c++) begin
            if (c < 30) step(1'b1, (c == 2), 1'b0);
            else step(1'b1, ($urandom_range(0, 14) == 0), ($urandom_range(0, 3) == 0));
        end
        chk("wrap_a0", {lg_addr[3], lg_addr[8]}, {8'd6, 8'd7});
        chk("wrap_a2", {lg_addr[13], lg_addr[18]}, {8'd0, 8'd1});
        chk("wrap_gap", {28'd0, lg_rden[3], lg_rden[8], lg_rden[13], lg_rden[18]}, 32'hF);
        model_check(1, "wrap");

        // Continuous mode, enable dropped at cycle 100.
        begin_scn(2);
        for (int c = 0; c < 150; c++) begin
            if (c < 30) step(1'b1, 1'b0, 1'b0);
            else step((c < 100), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
        end
        chk("cont_gap", {29'd0, lg_done[13], lg_busy[14], lg_rden[15]}, 32'd5);
        begin
            int nb = 0;
            for (int c = 130; c < 150; c++) if (lg_busy[c]) nb++;
            chk("cont_stop", nb, 32'd0);
        end
        model_check(2, "cont");

        // Asynchronous reset between edges in the middle of a burst.
        begin_scn(0);
        step(1'b1, 1'b1, 1'b0);
        for (int c = 1; c < 6; c++) step(1'b1, 1'b0, 1'b0);
        chk("arst_busy", {31'd0, o_busy[0]}, 32'd1);
        @(posedge clock); #3;
        rst_i[0] = 1'b1;
        #1;
        chk_rst(0, "arst");
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk($sformatf("arst_quiet%0d", c), {30'd0, o_wr[0], o_rden[0]}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
